// File: rtl/sample_sequencer_pkg.sv
// sample_sequencer_pkg: shared sizes and FSM encoding for the sample sequencer
package sample_sequencer_pkg;
    localparam int N_DEF = 16;
    localparam int DEPTH_DEF = 32;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);
    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
endpackage

// File: rtl/sample_sequencer_if.sv
// sample_sequencer_if: table write port, playback controls and sample stream
interface sample_sequencer_if
    import sample_sequencer_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();
    logic wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [N-1:0] wr_data;
    logic start;
    logic stop;
    logic loop_en;
    logic [7:0] rate_div;
    logic [N-1:0] data_out;
    logic data_valid;
    logic busy;
    logic done;
    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop_en, rate_div,
        input data_out, data_valid, busy, done
    );
    modport slave (
        input wr_en, wr_addr, wr_data, start, stop, loop_en, rate_div,
        output data_out, data_valid, busy, done
    );
endinterface

// File: rtl/sample_sequencer_ram.sv
// sample_ram: one write port, one registered read port, read-before-write
module sample_ram
    import sample_sequencer_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [N-1:0]      wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [N-1:0]      rdata
);
    logic [N-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // Only the read register is reset; table contents survive reset
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: plays a sample table at a programmable rate, single pass or looped
module sample_sequencer
    import sample_sequencer_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic clk,
    input logic reset,
    sample_sequencer_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    state_t state;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0] div_cnt;
    logic [7:0] rate_q;
    logic loop_q;
    logic tick;
    logic at_end;
    assign tick = state == PLAY && div_cnt == rate_q;
    assign at_end = rd_addr == ADDR_W'(DEPTH - 1);
    // A stop on a tick edge suppresses the read so data_out keeps the previous sample
    sample_ram #(.N(N), .DEPTH(DEPTH)) ram (
        .clk(clk),
        .rst(reset),
        .we(bus.wr_en && !reset),
        .waddr(bus.wr_addr),
        .wdata(bus.wr_data),
        .re(tick && !bus.stop),
        .raddr(rd_addr),
        .rdata(bus.data_out)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rd_addr <= '0;
            div_cnt <= '0;
            rate_q <= '0;
            loop_q <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start && !bus.stop) begin
                    state <= PLAY;
                    bus.busy <= 1'b1;
                    rd_addr <= '0;
                    div_cnt <= '0;
                    rate_q <= bus.rate_div;
                    loop_q <= bus.loop_en;
                end
            end else if (bus.stop) begin
                state <= IDLE;
                bus.busy <= 1'b0;
            end else if (tick) begin
                bus.data_valid <= 1'b1;
                rd_addr <= rd_addr + ADDR_W'(1);
                div_cnt <= '0;
                if (at_end && !loop_q) begin
                    bus.done <= 1'b1;
                    state <= IDLE;
                    bus.busy <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: scoreboard bench with an arithmetic playback-schedule model
module tb_sample_sequencer;
    import sample_sequencer_pkg::*;
    localparam int N = 16;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    typedef struct packed {logic busy; logic valid; logic done; logic [N-1:0] data;} status_t;
    typedef struct packed {logic done; logic [N-1:0] data;} sample_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    sample_sequencer_if #(.N(N), .ADDR_W(AW)) bus ();
    sample_sequencer #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    status_t stq[$];
    sample_t smq[$];
    status_t s_m;
    sample_t m_m;
    int compared = 0;
    int mismatched = 0;
    logic [N-1:0] tbl [DEPTH];
    bit playing = 0;
    bit lp = 0;
    int t0 = 0;
    int rr = 0;
    int ecount = 0;
    logic [N-1:0] last = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Predicts the outcome of the coming edge from the inputs currently applied
    task automatic model();
        status_t s;
        sample_t m;
        int el;
        int j;
        s = '0;
        if (reset) begin
            playing = 0;
            last = '0;
        end else begin
            if (!playing) begin
                if (bus.start && !bus.stop) begin
                    playing = 1;
                    t0 = ecount;
                    rr = int'(bus.rate_div);
                    lp = bus.loop_en;
                end
            end else if (bus.stop) begin
                playing = 0;
            end else begin
                el = ecount - t0 - 1 - rr;
                if (el >= 0 && el % (rr + 1) == 0) begin
                    j = el / (rr + 1);
                    last = tbl[j % DEPTH];
                    s.valid = 1'b1;
                    if (!lp && j == DEPTH - 1) begin
                        s.done = 1'b1;
                        playing = 0;
                    end
                    m.done = s.done;
                    m.data = last;
                    smq.push_back(m);
                end
            end
            if (bus.wr_en) tbl[bus.wr_addr] = bus.wr_data;
        end
        s.busy = playing;
        s.data = last;
        stq.push_back(s);
        ecount++;
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        if (stq.size() > 0) begin
            s_m = stq.pop_front();
            check("busy", 32'(bus.busy), 32'(s_m.busy));
            check("data_valid", 32'(bus.data_valid), 32'(s_m.valid));
            check("done", 32'(bus.done), 32'(s_m.done));
            check("data_out", 32'(bus.data_out), 32'(s_m.data));
            if (bus.data_valid) begin
                if (smq.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sample: unexpected data_valid with data %h, none expected", bus.data_out);
                end else begin
                    m_m = smq.pop_front();
                    check("sample_data", 32'(bus.data_out), 32'(m_m.data));
                    check("sample_done", 32'(bus.done), 32'(m_m.done));
                end
            end
        end
    end

    initial begin
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 0; bus.stop = 0; bus.loop_en = 0; bus.rate_div = '0;
        reset = 1;
        steps(3);
        reset = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en = 1; bus.wr_addr = AW'(i); bus.wr_data = N'(i * 16'h0101);
            step();
        end
        bus.wr_en = 0;
        reset = 1; bus.wr_en = 1; bus.wr_addr = 5'd7; bus.wr_data = 16'hBEEF;
        step();
        reset = 0; bus.wr_en = 0;
        // single pass at full rate
        bus.start = 1; step(); bus.start = 0;
        steps(40);
        // looped at rate 3, with start and setting changes ignored mid-play
        bus.rate_div = 8'd3; bus.loop_en = 1; bus.start = 1; step();
        for (int i = 0; i < 282; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.rate_div = 8'($urandom);
            bus.loop_en = 1'($urandom_range(0, 1));
            step();
        end
        bus.start = 0; bus.rate_div = '0; bus.loop_en = 0;
        bus.stop = 1; step(); bus.stop = 0; steps(2);
        // stop on the 10th tick
        bus.start = 1; step(); bus.start = 0;
        steps(9);
        bus.stop = 1; step(); bus.stop = 0;
        steps(3);
        // reset on the 5th tick, then restart
        bus.start = 1; step(); bus.start = 0;
        steps(4);
        reset = 1; step(); reset = 0;
        steps(2);
        bus.start = 1; step(); bus.start = 0;
        steps(5);
        bus.stop = 1; step(); bus.stop = 0;
        // start and stop together while idle
        bus.start = 1; bus.stop = 1; steps(3);
        bus.start = 0; bus.stop = 0; steps(2);
        // write address 4 on the edge that reads it
        bus.start = 1; step(); bus.start = 0;
        steps(4);
        bus.wr_en = 1; bus.wr_addr = 5'd4; bus.wr_data = 16'hABCD; step(); bus.wr_en = 0;
        steps(40);
        bus.start = 1; step(); bus.start = 0;
        steps(40);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.start = ($urandom_range(0, 7) == 0);
            bus.stop = ($urandom_range(0, 31) == 0);
            bus.rate_div = 8'($urandom_range(0, 3));
            bus.loop_en = 1'($urandom_range(0, 1));
            bus.wr_en = ($urandom_range(0, 3) == 0);
            bus.wr_addr = AW'($urandom_range(0, DEPTH - 1));
            bus.wr_data = N'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        bus.start = 0; bus.stop = 1; bus.wr_en = 0; reset = 0;
        step();
        bus.stop = 0;
        steps(3);
        @(negedge clk);
        #1;
        compared++;
        if (smq.size() != 0 || stq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d samples and %0d cycles left unchecked, required 0", smq.size(), stq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
